// File: rtl/rs_station_param_pkg.sv
// Shared defaults and CDB bus slicing helper
// for the parametrised reservation station.
package rs_station_param_pkg;

  localparam int RS_DEPTH_D = 16;
  localparam int RS_IDX_W_D = 4;
  localparam int ROB_W_D    = 4;
  localparam int DATA_W_D   = 32;
  localparam int OP_W_D     = 6;
  localparam int IMM_W_D    = 32;
  localparam int ADDR_W_D   = 32;
  localparam int CDB_N_D    = 2;

  // Low bit of port p in a bus packed w bits per port.
  function automatic int slot_lo(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/rs_station_param_if.sv
// Dispatcher/ALU/CDB bundle of the reservation station.
// master: dispatcher side, slave: the station itself.
interface rs_station_param_if #(
  parameter int RS_IDX_W = 4,
  parameter int ROB_W    = 4,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 6,
  parameter int IMM_W    = 32,
  parameter int ADDR_W   = 32,
  parameter int CDB_N    = 2
);

  logic                    ready;
  logic                    flush;
  logic [ROB_W-1:0]        rob_head;

  logic                    push_valid;
  logic                    push_ready;
  logic [OP_W-1:0]         push_op;
  logic [IMM_W-1:0]        push_imm;
  logic [ADDR_W-1:0]       push_pc;
  logic [ROB_W-1:0]        push_robpos;
  logic [DATA_W-1:0]       push_vj;
  logic [DATA_W-1:0]       push_vk;
  logic                    push_qj;
  logic                    push_qk;

  logic                    issue_valid;
  logic                    issue_ready;
  logic [OP_W-1:0]         issue_op;
  logic [IMM_W-1:0]        issue_imm;
  logic [ADDR_W-1:0]       issue_pc;
  logic [ROB_W-1:0]        issue_robpos;
  logic [DATA_W-1:0]       issue_vj;
  logic [DATA_W-1:0]       issue_vk;

  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*ROB_W-1:0]  cdb_robpos;
  logic [CDB_N*DATA_W-1:0] cdb_val;

  logic [RS_IDX_W:0]       count;
  logic                    empty;

  modport master (
    output ready, flush, rob_head,
    output push_valid, push_op, push_imm, push_pc,
    output push_robpos, push_vj, push_vk,
    output push_qj, push_qk,
    output issue_ready,
    output cdb_valid, cdb_robpos, cdb_val,
    input  push_ready,
    input  issue_valid, issue_op, issue_imm,
    input  issue_pc, issue_robpos, issue_vj, issue_vk,
    input  count, empty
  );

  modport slave (
    input  ready, flush, rob_head,
    input  push_valid, push_op, push_imm, push_pc,
    input  push_robpos, push_vj, push_vk,
    input  push_qj, push_qk,
    input  issue_ready,
    input  cdb_valid, cdb_robpos, cdb_val,
    output push_ready,
    output issue_valid, issue_op, issue_imm,
    output issue_pc, issue_robpos, issue_vj, issue_vk,
    output count, empty
  );

endinterface

// File: rtl/rs_station_param_age_select.sv
// Oldest-ready picker: ready vector + ROB indices in,
// o_found/o_idx of min (rob - head) mod 2^ROB_W out.
module rs_station_param_age_select #(
  parameter int RS_DEPTH = 16,
  parameter int RS_IDX_W = 4,
  parameter int ROB_W    = 4
) (
  input  logic [RS_DEPTH-1:0]            i_rdy,
  input  logic [RS_DEPTH-1:0][ROB_W-1:0] i_rob,
  input  logic [ROB_W-1:0]               i_head,
  output logic                           o_found,
  output logic [RS_IDX_W-1:0]            o_idx
);

  logic                w_found;
  logic [RS_IDX_W-1:0] w_idx;
  logic [ROB_W-1:0]    w_age;
  logic [ROB_W-1:0]    w_best;

  // Strict '<' keeps the lowest index on an age tie.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_age   = '0;
    w_best  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_age = i_rob[i] - i_head;
      if (i_rdy[i] && (!w_found || w_age < w_best)) begin
        w_found = 1'b1;
        w_idx   = RS_IDX_W'(i);
        w_best  = w_age;
      end
    end
  end

  assign o_found = w_found;
  assign o_idx   = w_idx;

endmodule

// File: rtl/rs_station_param.sv
// Reservation station: holds renamed ops until operands arrive,
// issues oldest ready one per cycle. Ports: clk, reset, bus.
module rs_station_param
  import rs_station_param_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_D,
  parameter int RS_IDX_W = RS_IDX_W_D,
  parameter int ROB_W    = ROB_W_D,
  parameter int DATA_W   = DATA_W_D,
  parameter int OP_W     = OP_W_D,
  parameter int IMM_W    = IMM_W_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int CDB_N    = CDB_N_D
) (
  input logic               clk,
  input logic               reset,
  rs_station_param_if.slave bus
);

  localparam int CW = RS_IDX_W + 1;

  logic [RS_DEPTH-1:0]            r_busy;
  logic [RS_DEPTH-1:0]            r_qj;
  logic [RS_DEPTH-1:0]            r_qk;
  logic [RS_DEPTH-1:0][ROB_W-1:0] r_rob;
  logic [OP_W-1:0]                r_op  [RS_DEPTH];
  logic [IMM_W-1:0]               r_imm [RS_DEPTH];
  logic [ADDR_W-1:0]              r_pc  [RS_DEPTH];
  logic [DATA_W-1:0]              r_vj  [RS_DEPTH];
  logic [DATA_W-1:0]              r_vk  [RS_DEPTH];

  logic                           r_iv;
  logic [OP_W-1:0]                r_iop;
  logic [IMM_W-1:0]               r_iimm;
  logic [ADDR_W-1:0]              r_ipc;
  logic [ROB_W-1:0]               r_irob;
  logic [DATA_W-1:0]              r_ivj;
  logic [DATA_W-1:0]              r_ivk;
  logic [CW-1:0]                  r_cnt;

  logic                           w_push_ready;
  logic                           w_push;
  logic                           w_take;
  logic                           w_found;
  logic [RS_IDX_W-1:0]            w_sel;
  logic [RS_IDX_W-1:0]            w_free;
  logic [RS_DEPTH-1:0]            w_rdy;
  logic [DATA_W:0]                w_bj;
  logic [DATA_W:0]                w_bk;
  logic [DATA_W:0]                w_wj  [RS_DEPTH];
  logic [DATA_W:0]                w_wk  [RS_DEPTH];

  // {hit, value}; scanning down lets the lowest port win.
  function automatic logic [DATA_W:0] f_cdb(
    input logic [ROB_W-1:0]        tag,
    input logic [CDB_N-1:0]        v,
    input logic [CDB_N*ROB_W-1:0]  t,
    input logic [CDB_N*DATA_W-1:0] d
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int p = CDB_N - 1; p >= 0; p--) begin
      if (v[p] && t[slot_lo(p, ROB_W) +: ROB_W] == tag)
        res = {1'b1, d[slot_lo(p, DATA_W) +: DATA_W]};
    end
    return res;
  endfunction

  // Full means no push, even if an entry issues this cycle.
  assign w_push_ready = r_cnt < CW'(RS_DEPTH);
  assign w_push = bus.push_valid && w_push_ready &&
                  bus.ready && !bus.flush;
  assign w_rdy  = r_busy & ~r_qj & ~r_qk;
  assign w_take = bus.ready && !bus.flush && w_found &&
                  (!r_iv || bus.issue_ready);

  always_comb begin
    w_free = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!r_busy[i]) w_free = RS_IDX_W'(i);
  end

  always_comb begin
    w_bj = f_cdb(bus.push_vj[ROB_W-1:0], bus.cdb_valid,
                 bus.cdb_robpos, bus.cdb_val);
    w_bk = f_cdb(bus.push_vk[ROB_W-1:0], bus.cdb_valid,
                 bus.cdb_robpos, bus.cdb_val);
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_wj[i] = f_cdb(r_vj[i][ROB_W-1:0], bus.cdb_valid,
                      bus.cdb_robpos, bus.cdb_val);
      w_wk[i] = f_cdb(r_vk[i][ROB_W-1:0], bus.cdb_valid,
                      bus.cdb_robpos, bus.cdb_val);
    end
  end

  rs_station_param_age_select #(
    .RS_DEPTH (RS_DEPTH),
    .RS_IDX_W (RS_IDX_W),
    .ROB_W    (ROB_W)
  ) u_sel (
    .i_rdy   (w_rdy),
    .i_rob   (r_rob),
    .i_head  (bus.rob_head),
    .o_found (w_found),
    .o_idx   (w_sel)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy <= '0;
      r_iv   <= 1'b0;
      r_cnt  <= '0;
      r_iop  <= '0;
      r_iimm <= '0;
      r_ipc  <= '0;
      r_irob <= '0;
      r_ivj  <= '0;
      r_ivk  <= '0;
    end else if (bus.ready) begin
      if (bus.flush) begin
        r_busy <= '0;
        r_iv   <= 1'b0;
        r_cnt  <= '0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (r_busy[i] && r_qj[i] && w_wj[i][DATA_W]) begin
            r_vj[i] <= w_wj[i][DATA_W-1:0];
            r_qj[i] <= 1'b0;
          end
          if (r_busy[i] && r_qk[i] && w_wk[i][DATA_W]) begin
            r_vk[i] <= w_wk[i][DATA_W-1:0];
            r_qk[i] <= 1'b0;
          end
        end
        if (w_take) begin
          r_iv          <= 1'b1;
          r_iop         <= r_op[w_sel];
          r_iimm        <= r_imm[w_sel];
          r_ipc         <= r_pc[w_sel];
          r_irob        <= r_rob[w_sel];
          r_ivj         <= r_vj[w_sel];
          r_ivk         <= r_vk[w_sel];
          r_busy[w_sel] <= 1'b0;
        end else if (bus.issue_ready) begin
          r_iv <= 1'b0;
        end
        if (w_push) begin
          r_busy[w_free] <= 1'b1;
          r_op[w_free]   <= bus.push_op;
          r_imm[w_free]  <= bus.push_imm;
          r_pc[w_free]   <= bus.push_pc;
          r_rob[w_free]  <= bus.push_robpos;
          r_qj[w_free]   <= bus.push_qj && !w_bj[DATA_W];
          r_qk[w_free]   <= bus.push_qk && !w_bk[DATA_W];
          r_vj[w_free]   <= (bus.push_qj && w_bj[DATA_W]) ?
                            w_bj[DATA_W-1:0] : bus.push_vj;
          r_vk[w_free]   <= (bus.push_qk && w_bk[DATA_W]) ?
                            w_bk[DATA_W-1:0] : bus.push_vk;
        end
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_take);
      end
    end
  end

  assign bus.push_ready   = w_push_ready;
  assign bus.issue_valid  = r_iv;
  assign bus.issue_op     = r_iop;
  assign bus.issue_imm    = r_iimm;
  assign bus.issue_pc     = r_ipc;
  assign bus.issue_robpos = r_irob;
  assign bus.issue_vj     = r_ivj;
  assign bus.issue_vk     = r_ivk;
  assign bus.count        = r_cnt;
  assign bus.empty        = (r_cnt == '0);

endmodule

// File: tb/tb_rs_station_param.sv
// Randomised bench for rs_station_param against a
// queue-based model of the station.
module tb_rs_station_param;
  import rs_station_param_pkg::*;

  localparam int RS_DEPTH = 16;
  localparam int RS_IDX_W = 4;
  localparam int ROB_W    = 4;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 6;
  localparam int IMM_W    = 32;
  localparam int ADDR_W   = 32;
  localparam int CDB_N    = 2;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] pc;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic              qj;
    logic              qk;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rs_station_param_if #(
    .RS_IDX_W(RS_IDX_W), .ROB_W(ROB_W), .DATA_W(DATA_W),
    .OP_W(OP_W), .IMM_W(IMM_W), .ADDR_W(ADDR_W),
    .CDB_N(CDB_N)
  ) bus ();

  rs_station_param #(
    .RS_DEPTH(RS_DEPTH), .RS_IDX_W(RS_IDX_W),
    .ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W),
    .IMM_W(IMM_W), .ADDR_W(ADDR_W), .CDB_N(CDB_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ent_t m_q[$];
  ent_t m_is;
  bit   m_iv;
  int   n_chk;
  int   n_fail;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int age_of(input logic [ROB_W-1:0] r);
    return (int'(r) - int'(bus.rob_head) + (1 << ROB_W))
           % (1 << ROB_W);
  endfunction

  function automatic bit cdb_find(input logic [ROB_W-1:0] tag,
                                  output logic [DATA_W-1:0] v);
    v = '0;
    for (int p = 0; p < CDB_N; p++)
      if (bus.cdb_valid[p] &&
          bus.cdb_robpos[p*ROB_W +: ROB_W] == tag) begin
        v = bus.cdb_val[p*DATA_W +: DATA_W];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bit in_use(input logic [ROB_W-1:0] r);
    foreach (m_q[i]) if (m_q[i].rob == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int sel;
    int best;
    bit acc;
    logic [DATA_W-1:0] v;
    ent_t e;
    if (!reset) begin
      m_q.delete();
      m_iv = 1'b0;
      m_is = '0;
      return;
    end
    if (!bus.ready) return;
    if (bus.flush) begin
      m_q.delete();
      m_iv = 1'b0;
      return;
    end
    sel  = -1;
    best = 0;
    foreach (m_q[i])
      if (!m_q[i].qj && !m_q[i].qk &&
          (sel < 0 || age_of(m_q[i].rob) < best)) begin
        sel  = i;
        best = age_of(m_q[i].rob);
      end
    acc = bus.push_valid && (m_q.size() < RS_DEPTH);
    foreach (m_q[i]) begin
      if (m_q[i].qj && cdb_find(m_q[i].vj[ROB_W-1:0], v)) begin
        m_q[i].vj = v;
        m_q[i].qj = 1'b0;
      end
      if (m_q[i].qk && cdb_find(m_q[i].vk[ROB_W-1:0], v)) begin
        m_q[i].vk = v;
        m_q[i].qk = 1'b0;
      end
    end
    if ((!m_iv || bus.issue_ready) && sel >= 0) begin
      m_is = m_q[sel];
      m_iv = 1'b1;
      m_q.delete(sel);
    end else if (bus.issue_ready) begin
      m_iv = 1'b0;
    end
    if (acc) begin
      e.op  = bus.push_op;
      e.imm = bus.push_imm;
      e.pc  = bus.push_pc;
      e.rob = bus.push_robpos;
      e.vj  = bus.push_vj;
      e.vk  = bus.push_vk;
      e.qj  = bus.push_qj;
      e.qk  = bus.push_qk;
      if (e.qj && cdb_find(e.vj[ROB_W-1:0], v)) begin
        e.vj = v;
        e.qj = 1'b0;
      end
      if (e.qk && cdb_find(e.vk[ROB_W-1:0], v)) begin
        e.vk = v;
        e.qk = 1'b0;
      end
      m_q.push_back(e);
    end
  endtask

  task automatic compare_all();
    chk("issue_valid", bus.issue_valid, m_iv);
    chk("count", bus.count, m_q.size());
    chk("empty", bus.empty, m_q.size() == 0);
    chk("push_ready", bus.push_ready, m_q.size() < RS_DEPTH);
    chk("issue_fields",
        {bus.issue_op, bus.issue_imm, bus.issue_pc,
         bus.issue_robpos, bus.issue_vj, bus.issue_vk},
        {m_is.op, m_is.imm, m_is.pc, m_is.rob, m_is.vj, m_is.vk});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.push_valid = 1'b0;
    bus.cdb_valid  = '0;
    bus.flush      = 1'b0;
    bus.ready      = 1'b1;
  endtask

  task automatic set_push(input int rob,
                          input logic [DATA_W-1:0] vj, input bit qj,
                          input logic [DATA_W-1:0] vk, input bit qk);
    bus.push_valid  = 1'b1;
    bus.push_op     = OP_W'($urandom);
    bus.push_imm    = $urandom;
    bus.push_pc     = $urandom;
    bus.push_robpos = ROB_W'(rob);
    bus.push_vj     = vj;
    bus.push_qj     = qj;
    bus.push_vk     = vk;
    bus.push_qk     = qk;
  endtask

  task automatic set_cdb(input int p, input int tag,
                         input logic [DATA_W-1:0] val);
    bus.cdb_valid[p] = 1'b1;
    bus.cdb_robpos[p*ROB_W +: ROB_W] = ROB_W'(tag);
    bus.cdb_val[p*DATA_W +: DATA_W]  = val;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_iv   = 1'b0;
    m_is   = '0;
    reset  = 1'b0;
    idle();
    bus.rob_head    = '0;
    bus.issue_ready = 1'b1;
    bus.cdb_robpos  = '0;
    bus.cdb_val     = '0;
    set_push(0, 0, 0, 0, 0);
    bus.push_valid  = 1'b0;
    tick();
    chk("rst_count", bus.count, 0);
    chk("rst_valid", bus.issue_valid, 0);
    reset = 1'b1;

    // ready operands: issue one edge after the push
    set_push(0, 5, 0, 7, 0);
    tick();
    idle();
    tick();
    chk("t1_valid", bus.issue_valid, 1);
    chk("t1_vj", bus.issue_vj, 5);
    chk("t1_vk", bus.issue_vk, 7);
    tick();
    chk("t1_count", bus.count, 0);

    // CDB wakeup on port 1, then push-time bypass on port 0
    set_push(1, 3, 1, 9, 0);
    tick();
    idle();
    tick();
    set_cdb(1, 3, 32'hDEAD);
    tick();
    idle();
    tick();
    chk("t2_wake_vj", bus.issue_vj, 32'hDEAD);
    set_push(2, 5, 1, 4, 0);
    set_cdb(0, 5, 32'hBEEF);
    set_cdb(1, 5, 32'h1111);
    tick();
    idle();
    tick();
    chk("t2_bypass_vj", bus.issue_vj, 32'hBEEF);
    tick();

    // three entries woken together; oldest by wrapped age first
    bus.rob_head = 4'd14;
    set_push(1, 9, 1, 0, 0);
    tick();
    set_push(15, 9, 1, 0, 0);
    tick();
    set_push(14, 9, 1, 0, 0);
    tick();
    idle();
    set_cdb(0, 9, 32'h42);
    tick();
    idle();
    tick();
    chk("t3_first", bus.issue_robpos, 14);
    tick();
    chk("t3_second", bus.issue_robpos, 15);
    tick();
    chk("t3_third", bus.issue_robpos, 1);
    tick();
    tick();

    // fill to capacity behind a stalled issue register
    bus.issue_ready = 1'b0;
    for (int i = 0; i <= RS_DEPTH; i++) begin
      set_push(i % 16, 100 + i, 0, 200 + i, 0);
      tick();
    end
    chk("t4_count_full", bus.count, RS_DEPTH);
    chk("t4_push_ready", bus.push_ready, 0);
    for (int i = 0; i < 5; i++) begin
      set_push(3, 1, 0, 1, 0);
      tick();
      chk("t4_hold_vj", bus.issue_vj, 100);
      chk("t4_hold_rob", bus.issue_robpos, 0);
    end
    bus.issue_ready = 1'b1;
    tick();
    chk("t4_no_reuse", bus.count, RS_DEPTH - 1);
    idle();
    for (int i = 0; i < RS_DEPTH - 1; i++) begin
      tick();
      chk("t4_drain", bus.count, RS_DEPTH - 2 - i);
    end
    tick();
    tick();

    // flush with a simultaneous push
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_push(i, i, 0, i, 0);
      tick();
    end
    chk("t5_pre_count", bus.count, 4);
    set_push(7, 77, 0, 77, 0);
    bus.flush = 1'b1;
    tick();
    chk("t5_count", bus.count, 0);
    chk("t5_valid", bus.issue_valid, 0);
    idle();
    bus.issue_ready = 1'b1;
    tick();
    chk("t5_absent", bus.issue_valid, 0);

    // ready low freezes everything
    set_push(3, 7, 1, 0, 0);
    tick();
    bus.ready = 1'b0;
    set_push(4, 1, 0, 1, 0);
    set_cdb(0, 7, 32'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_frozen", bus.count, 1);
    end
    idle();
    tick();
    set_cdb(1, 7, 32'h99);
    tick();
    idle();
    tick();
    chk("t6_wake", bus.issue_vj, 32'h99);

    // randomised traffic with a reset in the middle
    for (int c = 0; c < 3000; c++) begin
      int r;
      bus.ready       = ($urandom % 8) != 0;
      bus.flush       = ($urandom % 64) == 0;
      bus.issue_ready = ($urandom % 10) < 7;
      if (c % 16 == 0) bus.rob_head = ROB_W'($urandom);
      bus.push_valid = 1'b0;
      if (m_q.size() < 12 && ($urandom % 10) < 6) begin
        do r = int'($urandom % 16); while (in_use(ROB_W'(r)));
        set_push(r, $urandom, bit'($urandom % 2),
                 $urandom, bit'($urandom % 2));
      end
      bus.cdb_valid = '0;
      for (int p = 0; p < CDB_N; p++)
        if (($urandom % 10) < 4)
          set_cdb(p, int'($urandom % 16), $urandom);
      reset = (c != 1500);
      tick();
      if (c == 1500) begin
        chk("rnd_rst_count", bus.count, 0);
        chk("rnd_rst_valid", bus.issue_valid, 0);
      end
    end
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_station_param.md
Name: rs_station_param

Overview:
- Parametrised successor to the single-port reservation station: depth, operand/field widths and the number of common-data-bus (CDB) wakeup ports are all generic.
- Adds a valid/ready push and issue handshake, oldest-first issue selection by ROB age, and a pipeline flush for branch mispredicts.
- Sits between the dispatcher and the ALU. It holds renamed instructions until both operands are available, then issues one per cycle.

Parameters:
- RS_DEPTH, 16, number of entries (power of 2, ≥2)
- RS_IDX_W, 4, log2(RS_DEPTH)
- ROB_W, 4, ROB index width; also the tag width carried in vj/vk while waiting
- DATA_W, 32, operand/result width
- OP_W, 6, decoded opcode width
- IMM_W, 32, immediate width
- ADDR_W, 32, PC width
- CDB_N, 2, number of result broadcast ports (ALU, LSB, ...)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ready  in  1  global enable; when 0 all state holds
- flush  in  1  discard all entries (mispredict)
- rob_head  in  ROB_W  oldest in-flight ROB index, used as the age reference
- push_valid  in  1  dispatcher offers an instruction
- push_ready  out  1  entry free (count < RS_DEPTH)
- push_op / push_imm / push_pc / push_robpos  in  OP_W / IMM_W / ADDR_W / ROB_W  instruction fields
- push_vj, push_vk  in  DATA_W  value, or tag in [ROB_W-1:0] when waiting
- push_qj, push_qk  in  1  1 = operand waiting on that tag
- issue_valid  out  1  issue register holds a ready instruction
- issue_ready  in  1  ALU accepts this cycle
- issue_op / issue_imm / issue_pc / issue_robpos / issue_vj / issue_vk  out  matching widths  issued fields
- cdb_valid  in  CDB_N  per-port broadcast valid
- cdb_robpos  in  CDB_N*ROB_W  packed tags; port p occupies bits [p*ROB_W +: ROB_W]
- cdb_val  in  CDB_N*DATA_W  packed values, same packing
- count  out  RS_IDX_W+1  occupied entries
- empty  out  1  count == 0

Behaviour:
- Reset (reset==0 at posedge): all busy=0, issue_valid=0, count=0. Issue fields are held at 0. Reset takes priority over ready and flush.
- ready==0: no state changes. Outputs hold; push_ready is still driven from count.
- Push handshake: a push is accepted when push_valid && push_ready && ready && !flush.
- Allocation: the lowest-index free entry, chosen combinationally.
- Push-time bypass: for each of qj/qk, if the operand is waiting and any cdb port matches its tag in the same cycle, store that cdb_val with q=0. Lowest port index wins on duplicate tags.
- Wakeup: each posedge, every busy entry with q set compares its tag against all CDB_N ports. On a match it captures the value and clears q. Lowest port index wins.
- Readiness: an entry is ready when busy && !qj && !qk, evaluated on registered state only. Same-cycle CDB results do not make an entry eligible until the next cycle.
- Selection: among ready entries, pick the minimum of (robpos - rob_head) mod 2^ROB_W. Ties cannot occur; if they do, lowest index wins.
- Issue register load: when (!issue_valid || issue_ready) and a ready entry exists, load its fields into the issue register, set issue_valid=1 and free the entry.
- Issue register clear: if issue_ready is asserted and nothing is ready, issue_valid goes to 0.
- Issue stall: when issue_valid && !issue_ready, the issue register and all of its fields hold stable.
- Latency: push accepted at edge t → issue_valid high after edge t+1 at the earliest (both operands ready at push). A CDB wakeup at edge t → issue after edge t+1 at the earliest.
- count update: next count = count + push_accept - entry_freed_to_issue_reg.
- When full: push_ready=0 even if an entry frees in the same cycle (no same-cycle slot reuse).
- Flush (flush==1 && ready): clear all busy bits and issue_valid, set count=0, and ignore any push that cycle. CDB inputs that cycle are ignored.
- Tag wrap-around: the age computation uses modulo-2^ROB_W subtraction, so a ROB index wrap is handled correctly.

Decomposition:
- Shared package (def.v): RS_DEPTH/RS_IDX_W, ROB_W, DATA_W, OP_W, IMM_W, ADDR_W, CDB_N defaults, plus the pack/unpack index macros for cdb buses.
- One natural sub-module, rs_age_select: a combinational oldest-ready picker. Inputs: ready vector, robpos array, rob_head. Outputs: found, index.

Test Plan:
1. Reset, then push op=ADD with vj=5, vk=7, both q=0, at edge 1, issue_ready=1 → issue_valid=1 after edge 2 with vj=5, vk=7; count returns to 0.
2. Push with qj=1, tag 3. Two cycles later cdb port1 broadcasts robpos=3, val=0xDEAD → entry vj=0xDEAD; issue on the following cycle. The same tag pushed coincident with the cdb broadcast → captured via bypass.
3. rob_head=14; push ready entries with robpos 1, 15, 14 → issue order 14, 15, 1 (wrap-around age).
4. Fill 16 entries with issue_ready=0 → push_ready=0, count=16. The issue register holds stable for 5 cycles; after raising issue_ready, one entry drains per cycle.
5. With 4 entries and issue_valid=1, assert flush together with push_valid → next cycle count=0, issue_valid=0, and the pushed instruction is absent.
6. Hold ready=0 for 3 cycles while a cdb broadcast and a push occur → no state change. Pull reset low mid-stream → all outputs return to their reset values next edge.
